// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the tournament branch predictor.
// Holds the table index width, the 2-bit counter encodings and the
// reset values of the pattern and chooser tables.
package branch_predictor_pkg;

  localparam int PRED_TABLE_BIT  = 8;
  localparam int PRED_TABLE_SIZE = 1 << PRED_TABLE_BIT;

  typedef logic [PRED_TABLE_BIT-1:0] idx_t;

  // 2-bit saturating counter states; bit 1 is the "taken" / "prefer global" bit
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] PHT_RESET     = 2'(WNT);
  // Chooser starts weakly preferring the local predictor
  localparam logic [1:0] CHOOSER_RESET = 2'(WNT);

endpackage

// File: rtl/branch_predictor_if.sv
// Query/response and commit-update bundle between the predictor and
// its front end (instruction unit) / back end (ROB).
// master = instruction unit + ROB side, slave = predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic        query_req;
  logic [31:0] query_pc;
  logic        pred_valid;
  logic        pred_taken;
  idx_t        pred_g_ind;
  idx_t        pred_l_ind;
  logic        br_ready;
  logic [31:0] br_res;
  logic        br_correct;
  idx_t        br_g_ind;
  idx_t        br_l_ind;

  modport master (
    output query_req, query_pc, br_ready, br_res, br_correct, br_g_ind, br_l_ind,
    input  pred_valid, pred_taken, pred_g_ind, pred_l_ind
  );

  modport slave (
    input  query_req, query_pc, br_ready, br_res, br_correct, br_g_ind, br_l_ind,
    output pred_valid, pred_taken, pred_g_ind, pred_l_ind
  );

endinterface

// File: rtl/branch_predictor_bp_sat_ctr2.sv
// Combinational 2-bit saturating up/down counter step.
// Shared by the gshare, local and chooser update paths.
module bp_sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] next
);

  // Step one towards ST when up, towards SNT otherwise; hold at the ends
  always_comb begin
    next = ctr;
    if (up) begin
      if (ctr != 2'(ST)) next = ctr + 2'd1;
    end else begin
      if (ctr != 2'(SNT)) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tournament branch predictor: gshare + local PHTs and a chooser, all
// 2-bit saturating counters. Queries answer one cycle later; training
// and the (non-speculative) global history follow the ROB commit stream.
// Optional build macro BP_STATS_EN adds commit correct/mispredict counters.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  branch_predictor_if.slave bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_correct,
  output logic [31:0]       stat_mispred
`endif
);

  logic [1:0] g_pht   [PRED_TABLE_SIZE];
  logic [1:0] l_pht   [PRED_TABLE_SIZE];
  logic [1:0] chooser [PRED_TABLE_SIZE];
  idx_t       ghr;

  // Query side: indices and direction read from pre-update state
  idx_t l_idx;
  idx_t g_idx;
  logic query_taken;

  assign l_idx       = bus.query_pc[PRED_TABLE_BIT+1:2];
  assign g_idx       = l_idx ^ ghr;
  assign query_taken = chooser[l_idx][1] ? g_pht[g_idx][1] : l_pht[l_idx][1];

  // Update side: current entries and their trained values
  logic       br_taken;
  logic       do_update;
  logic [1:0] g_cur, l_cur, c_cur;
  logic [1:0] g_next, l_next, c_next;
  logic       g_right, l_right;

  assign br_taken  = bus.br_res[0];
  assign do_update = rdy_in && bus.br_ready;
  assign g_cur     = g_pht[bus.br_g_ind];
  assign l_cur     = l_pht[bus.br_l_ind];
  assign c_cur     = chooser[bus.br_l_ind];
  assign g_right   = (g_cur[1] == br_taken);
  assign l_right   = (l_cur[1] == br_taken);

  bp_sat_ctr2 u_g_ctr (.ctr(g_cur), .up(br_taken), .next(g_next));
  bp_sat_ctr2 u_l_ctr (.ctr(l_cur), .up(br_taken), .next(l_next));
  // Chooser moves towards whichever predictor alone was right
  bp_sat_ctr2 u_c_ctr (.ctr(c_cur), .up(g_right),  .next(c_next));

  logic unused_bits;
  assign unused_bits = ^{bus.br_res[31:1], bus.query_pc[31:PRED_TABLE_BIT+2],
                         bus.query_pc[1:0], bus.br_correct};

  genvar gi;
  generate
    for (gi = 0; gi < PRED_TABLE_SIZE; gi++) begin : g_entry
      // Train one entry of each table when the commit update targets it
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          g_pht[gi]   <= PHT_RESET;
          l_pht[gi]   <= PHT_RESET;
          chooser[gi] <= CHOOSER_RESET;
        end else if (do_update) begin
          if (bus.br_g_ind == idx_t'(gi)) g_pht[gi] <= g_next;
          if (bus.br_l_ind == idx_t'(gi)) begin
            l_pht[gi] <= l_next;
            if (g_right != l_right) chooser[gi] <= c_next;
          end
        end
      end
    end
  endgenerate

  // Global history shifts in each committed outcome
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)        ghr <= '0;
    else if (do_update) ghr <= {ghr[PRED_TABLE_BIT-2:0], br_taken};
  end

  // Registered prediction response; payload holds when no query is accepted
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_g_ind <= '0;
      bus.pred_l_ind <= '0;
    end else if (rdy_in) begin
      bus.pred_valid <= bus.query_req && !clear_in;
      if (bus.query_req && !clear_in) begin
        bus.pred_taken <= query_taken;
        bus.pred_g_ind <= g_idx;
        bus.pred_l_ind <= l_idx;
      end
    end
  end

`ifdef BP_STATS_EN
  // Commit statistics, split by the ROB's correctness flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_correct <= '0;
      stat_mispred <= '0;
    end else if (do_update) begin
      if (bus.br_correct) stat_correct <= stat_correct + 32'd1;
      else                stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table plus
// randomized traffic against a behavioural tournament-predictor model.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;

  branch_predictor_if bus();

`ifdef BP_STATS_EN
  logic [31:0] stat_correct, stat_mispred;
`endif

  branch_predictor dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
`ifdef BP_STATS_EN
    ,
    .stat_correct (stat_correct),
    .stat_mispred (stat_mispred)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural reference model ----------------
  int m_g [256];
  int m_l [256];
  int m_c [256];
  int m_ghr;
  int m_sc, m_sm;
  bit e_v, e_t;
  int e_g, e_l;

  function automatic int bump(int v, bit up);
    if (up) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_g[i] = 1; m_l[i] = 1; m_c[i] = 1;
    end
    m_ghr = 0; m_sc = 0; m_sm = 0;
    e_v = 0; e_t = 0; e_g = 0; e_l = 0;
  endtask

  // One accepted clock edge (rdy high): predict from old state, then train
  task automatic model_step(bit clr, bit q, logic [31:0] pc, bit br,
                            logic [31:0] res, int gi, int li, bit corr);
    int l;
    bit t, gc, lc;
    l = int'(pc[9:2]);
    if (q && !clr) begin
      e_v = 1;
      e_l = l;
      e_g = l ^ m_ghr;
      e_t = (m_c[l] >= 2) ? (m_g[e_g] >= 2) : (m_l[l] >= 2);
    end else begin
      e_v = 0;
    end
    if (br) begin
      t  = res[0];
      gc = ((m_g[gi] >= 2) == t);
      lc = ((m_l[li] >= 2) == t);
      m_g[gi] = bump(m_g[gi], t);
      m_l[li] = bump(m_l[li], t);
      if (gc && !lc) m_c[li] = bump(m_c[li], 1);
      else if (lc && !gc) m_c[li] = bump(m_c[li], 0);
      m_ghr = ((m_ghr * 2) + int'(t)) % 256;
      if (corr) m_sc++; else m_sm++;
    end
  endtask

  // ---------------- driving / checking helpers ----------------
  task automatic drive(bit rdy, bit clr, bit q, logic [31:0] pc, bit br,
                       logic [31:0] res, logic [7:0] gi, logic [7:0] li, bit corr);
    rdy_in         = rdy;
    clear_in       = clr;
    bus.query_req  = q;
    bus.query_pc   = pc;
    bus.br_ready   = br;
    bus.br_res     = res;
    bus.br_g_ind   = gi;
    bus.br_l_ind   = li;
    bus.br_correct = corr;
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    drive(1, 0, 0, 32'h0, 0, 32'h0, 8'h0, 8'h0, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    model_reset();
  endtask

  task automatic check_out(string name, bit v, bit t, logic [7:0] g, logic [7:0] l);
    n_tests++;
    if (bus.pred_valid !== v || bus.pred_taken !== t ||
        bus.pred_g_ind !== g || bus.pred_l_ind !== l) begin
      n_fail++;
      $display("FAIL %s: got v=%0d t=%0d g=%02h l=%02h, expected v=%0d t=%0d g=%02h l=%02h",
               name, bus.pred_valid, bus.pred_taken, bus.pred_g_ind, bus.pred_l_ind,
               v, t, g, l);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic check_stats(string name, int sc, int sm);
    n_tests++;
    if (stat_correct !== 32'(sc) || stat_mispred !== 32'(sm)) begin
      n_fail++;
      $display("FAIL %s: got correct=%0d mispred=%0d, expected correct=%0d mispred=%0d",
               name, stat_correct, stat_mispred, sc, sm);
    end
  endtask
`endif

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          rdy;
    bit          clr;
    bit          q;
    logic [31:0] pc;
    bit          br;
    logic [31:0] res;
    logic [7:0]  gi;
    logic [7:0]  li;
    bit          ev;
    bit          et;
    logic [7:0]  eg;
    logic [7:0]  el;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit rdy, bit clr, bit q, logic [31:0] pc,
                              bit br, logic [31:0] res, logic [7:0] gi, logic [7:0] li,
                              bit ev, bit et, logic [7:0] eg, logic [7:0] el);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.clr = clr; v.q = q; v.pc = pc;
    v.br = br; v.res = res; v.gi = gi; v.li = li;
    v.ev = ev; v.et = et; v.eg = eg; v.el = el;
    return v;
  endfunction

  initial begin
    // Query after reset, then idle
    vecs.push_back(mk(1,1,0,1,32'h100, 0,32'h0,8'h00,8'h00, 1,0,8'h40,8'h40));
    vecs.push_back(mk(0,1,0,0,32'h0,   0,32'h0,8'h00,8'h00, 0,0,8'h40,8'h40));
    // Two taken commits at 0x40 -> GHR=3, local strongly taken
    vecs.push_back(mk(0,1,0,0,32'h0,   1,32'h1,8'h40,8'h40, 0,0,8'h40,8'h40));
    vecs.push_back(mk(0,1,0,0,32'h0,   1,32'h1,8'h40,8'h40, 0,0,8'h40,8'h40));
    vecs.push_back(mk(0,1,0,1,32'h100, 0,32'h0,8'h00,8'h00, 1,1,8'h43,8'h40));
    // Six not-taken commits at 0x10 (upper br_res bits set, ignored)
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,0,0,32'h0, 1,32'hFFFF_FFFE,8'h10,8'h10, 0,1,8'h43,8'h40));
    vecs.push_back(mk(0,1,0,1,32'h40,  0,32'h0,8'h00,8'h00, 1,0,8'hD0,8'h10));
    // One taken at 0x10: a saturated 00 becomes 01, still not taken
    vecs.push_back(mk(0,1,0,0,32'h0,   1,32'h1,8'h10,8'h10, 0,0,8'hD0,8'h10));
    vecs.push_back(mk(0,1,0,1,32'h40,  0,32'h0,8'h00,8'h00, 1,0,8'h91,8'h10));
    // Same-cycle query and update read old state; next query sees new
    vecs.push_back(mk(1,1,0,1,32'h100, 1,32'h1,8'h40,8'h40, 1,0,8'h40,8'h40));
    vecs.push_back(mk(0,1,0,1,32'h100, 0,32'h0,8'h00,8'h00, 1,1,8'h41,8'h40));
    // clear kills the query but the commit still trains
    vecs.push_back(mk(1,1,1,1,32'h100, 1,32'h1,8'h40,8'h40, 0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,1,32'h100, 0,32'h0,8'h00,8'h00, 1,1,8'h41,8'h40));
    // rdy low freezes outputs and state despite query/update traffic
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,0,1,32'h200, 1,32'h0,8'h40,8'h40, 1,1,8'h41,8'h40));
    vecs.push_back(mk(0,1,0,1,32'h100, 0,32'h0,8'h00,8'h00, 1,1,8'h41,8'h40));
    // Chooser flips to global at 0x40, global entry 0x4B trained taken
    vecs.push_back(mk(1,1,0,0,32'h0,   1,32'h1,8'h05,8'h40, 0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,32'h0,   1,32'h0,8'h06,8'h40, 0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,32'h0,   1,32'h1,8'h4B,8'h41, 0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,32'h0,   1,32'h1,8'h4B,8'h41, 0,0,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,1,32'h100, 0,32'h0,8'h00,8'h00, 1,1,8'h4B,8'h40));
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] pc, res;
    bit rdy, clr, q, br, corr;
    int li, gi;

    rst_in = 1'b0;
    drive(1, 0, 0, 32'h0, 0, 32'h0, 8'h0, 8'h0, 0);
    #1;
    do_reset();
    check_out("reset_state", 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].rdy, vecs[i].clr, vecs[i].q, vecs[i].pc, vecs[i].br,
            vecs[i].res, vecs[i].gi, vecs[i].li, 1'b0);
      cycle();
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et, vecs[i].eg, vecs[i].el);
    end

    // Asynchronous reset clears outputs mid-cycle
    do_reset();
    drive(1, 0, 1, 32'h104, 0, 32'h0, 8'h0, 8'h0, 0);
    cycle();
    check_out("pre_async_reset", 1, 0, 8'h41, 8'h41);
    drive(1, 0, 0, 32'h0, 0, 32'h0, 8'h0, 8'h0, 0);
    #2 rst_in = 1'b0;
    #1 check_out("async_reset", 0, 0, 8'h00, 8'h00);

`ifdef BP_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 32'h0, 1, 32'h1, 8'h20, 8'h20, (i < 3));
      cycle();
    end
    drive(0, 0, 0, 32'h0, 1, 32'h1, 8'h20, 8'h20, 1);
    cycle();
    check_stats("stats_count", 3, 2);
    #2 rst_in = 1'b0;
    #1 check_stats("stats_async_reset", 0, 0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rdy  = ($urandom_range(0, 7) != 0);
      clr  = ($urandom_range(0, 5) == 0);
      q    = $urandom_range(0, 1);
      li   = $urandom_range(0, 7);
      pc   = ($urandom & ~32'h3FC) | (32'(li) << 2);
      br   = $urandom_range(0, 1);
      res  = $urandom;
      li   = $urandom_range(0, 7);
      gi   = li ^ m_ghr;
      if ($urandom_range(0, 3) == 0) gi = $urandom_range(0, 255);
      corr = $urandom_range(0, 1);
      if (rdy) model_step(clr, q, pc, br, res, gi, li, corr);
      drive(rdy, clr, q, pc, br, res, 8'(gi), 8'(li), corr);
      cycle();
      check_out($sformatf("rand%0d", n), e_v, e_t, 8'(e_g), 8'(e_l));
`ifdef BP_STATS_EN
      check_stats($sformatf("rand_stats%0d", n), m_sc, m_sm);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Tournament branch predictor with gshare, local and chooser tables, all 2-bit saturating counters.
- Front end (instruction unit): the unit issues a query with the branch PC. One cycle later it receives a direction plus the table indices used, which it forwards to the ROB.
- Back end: the predictor consumes the ROB's commit-time update stream (br_ready/br_res/br_correct/br_g_ind/br_l_ind) and trains its tables and global history.

Parameters:
- PRED_TABLE_BIT, 8, index width; each table has 2^PRED_TABLE_BIT entries.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  pause when low.
- clear_in  in  1  misprediction flush from ROB.
- query_req  in  1  prediction request.
- query_pc  in  32  branch PC.
- pred_valid  out  1  response valid.
- pred_taken  out  1  predicted direction.
- pred_g_ind  out  PRED_TABLE_BIT  gshare index used.
- pred_l_ind  out  PRED_TABLE_BIT  local/chooser index used.
- br_ready  in  1  commit update strobe.
- br_res  in  32  actual outcome (bit 0 only).
- br_correct  in  1  ROB's prediction-correct flag (stats only).
- br_g_ind  in  PRED_TABLE_BIT  gshare index to train.
- br_l_ind  in  PRED_TABLE_BIT  local/chooser index to train.

Behaviour:
- Reset (rst_in low, async): all outputs 0; GHR = 0; every g_pht and l_pht entry = 2'b01; every chooser entry = 2'b01 (weakly local).
- rdy_in low: no state or output changes. Overrides query, update and clear.
- Index computation:
  - l_idx = query_pc[PRED_TABLE_BIT+1:2].
  - g_idx = l_idx XOR GHR.
- Query, latency 1 cycle:
  - If query_req && !clear_in at edge N, then after edge N: pred_valid=1, pred_l_ind=l_idx, pred_g_ind=g_idx.
  - pred_taken = chooser[l_idx][1] ? g_pht[g_idx][1] : l_pht[l_idx][1].
  - Otherwise pred_valid=0 and the other outputs hold their values.
- Update on br_ready at edge N (taken t = br_res[0]):
  - g_pht[br_g_ind] and l_pht[br_l_ind] count up if t, down if not t, saturating at 00 and 11.
  - Chooser[br_l_ind]: let gc = (g_pht[br_g_ind][1]==t) and lc = (l_pht[br_l_ind][1]==t), both using pre-update values. gc && !lc increments (sat); lc && !gc decrements (sat); otherwise unchanged.
  - GHR <= {GHR[PRED_TABLE_BIT-2:0], t}. The GHR is non-speculative and updates only at commit.
- Simultaneous query and update in the same cycle: the query reads pre-update tables and the pre-update GHR (read-before-write), including when the indices are the same.
- clear_in: suppresses that cycle's query, so pred_valid=0 next cycle. A br_ready arriving with clear_in (normal for a mispredicted commit) is still fully applied.
- Unused br_res bits are ignored. Wrap of index arithmetic is modulo 2^PRED_TABLE_BIT.

Optional Feature:
- BP_STATS_EN defined adds two outputs, stat_correct[31:0] and stat_mispred[31:0]:
  - Both reset to 0.
  - On each br_ready with rdy_in high, increment stat_correct if br_correct, else stat_mispred.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist. Prediction behaviour is identical either way.

Decomposition:
- Shared constants header (with the existing ROB/type constants): PRED_TABLE_BIT, counter encodings (SNT=00, WNT=01, WT=10, ST=11), chooser reset value.
- One sub-module: bp_sat_ctr2, a combinational 2-bit saturating inc/dec (in: ctr, up; out: next). It is instantiated for the g, l and chooser update paths.

Test Plan:
1. Reset, then query_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_l_ind=0x40, pred_g_ind=0x40; the cycle after with no query -> pred_valid=0.
2. Two br_ready, br_res=1, g_ind=l_ind=0x40 -> l_pht[0x40]=11, g_pht[0x40]=11, chooser[0x40]=01 unchanged, GHR=0x03. Query 0x100 -> pred_g_ind=0x43, pred_taken=1 (local chosen).
3. Five updates br_res=0 at l_ind=0x10 -> l_pht[0x10] saturates at 00; a sixth update leaves it 00 and the GHR shifts in 0 each time.
4. query_pc=0x100 and br_ready (t=1, idx 0x40) in the same cycle from reset -> pred_taken=0 (pre-update value); a query the next cycle sees the trained value/GHR.
5. clear_in with query_req and br_ready(t=1) -> pred_valid=0 next cycle; tables/GHR updated. rdy_in low for 3 cycles with query/update -> all state and outputs frozen.
6. BP_STATS_EN: 3 updates br_correct=1 and 2 with 0 -> stat_correct=3, stat_mispred=2; assert rst_in low mid-run -> both 0 immediately (async).
